// File: rtl/opposite_number_pkg.sv
// Shared mode encodings, FSM state type and the invert-decision helper
// for the digit-serial opposite-number unit.
package opposite_number_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_NABS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Whether the operand must be two's-complement negated for this mode and sign.
  function automatic logic invert_flag(input logic [1:0] mode, input logic msb);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && msb) || ((mode == MODE_NABS) && !msb);
  endfunction

endpackage

// File: rtl/opposite_number_digit.sv
// One DIGIT-bit slice of a conditional two's-complement negation:
// optionally inverts the digit and adds the incoming carry.
module opposite_number_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] d,
  input  logic             inv,
  input  logic             cin,
  output logic [DIGIT-1:0] r,
  output logic             cout
);

  assign {cout, r} = {1'b0, d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/opposite_number_serial.sv
// Digit-serial pass / negate / abs / neg-abs unit: consumes a WIDTH-bit signed
// operand LSB-first, DIGIT bits per cycle, with valid/ready on both sides.
module opposite_number_serial
  import opposite_number_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             inv;
  logic             carry;
  logic             opmsb;
  logic [DIGIT-1:0] r;
  logic             cout;
  logic             accept;
  logic             inv_in;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign inv_in   = invert_flag(in_mode, in_data[WIDTH-1]);

  opposite_number_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .d   (opnd[DIGIT-1:0]),
    .inv (inv),
    .cin (carry),
    .r   (r),
    .cout(cout)
  );

  // Result digits enter from the MSB side so the LSB digit ends up at the bottom.
  always_comb begin
    res_nx = res >> DIGIT;
    res_nx[WIDTH-1 -: DIGIT] = r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opnd      <= '0;
      res       <= '0;
      cnt       <= '0;
      inv       <= 1'b0;
      carry     <= 1'b0;
      opmsb     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      opnd      <= in_data;
      opmsb     <= in_data[WIDTH-1];
      inv       <= inv_in;
      carry     <= inv_in;
      cnt       <= '0;
      state     <= BUSY;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          opnd  <= opnd >> DIGIT;
          res   <= res_nx;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          // Final carry is dropped; only a negated MIN keeps its sign bit set.
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= res_nx;
            out_ovf   <= inv && opmsb && res_nx[WIDTH-1];
            out_zero  <= (res_nx == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opposite_number_serial.sv
// Bench for opposite_number_serial: six width/digit configurations checked
// against an integer-arithmetic model of pass/negate/abs/neg-abs.
module tb_opposite_number_serial;
  import opposite_number_pkg::*;

  localparam int NCFG = 6;
  localparam int CFG_W [NCFG] = '{8, 8, 8, 8, 16, 16};
  localparam int CFG_D [NCFG] = '{1, 2, 4, 8, 4, 16};

  typedef struct packed {
    logic        ovf;
    logic        zero;
    logic [15:0] data;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic [15:0]           in_data;
  logic [1:0]            in_mode;
  logic                  out_ready;
  logic [NCFG-1:0]       irdy;
  logic [NCFG-1:0]       ov;
  logic [NCFG-1:0]       oo;
  logic [NCFG-1:0]       oz;
  logic [NCFG-1:0][15:0] od;

  int   sel = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic fresh = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    logic [CFG_W[g]-1:0] dout;
    opposite_number_serial #(
      .WIDTH(CFG_W[g]),
      .DIGIT(CFG_D[g])
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid && (sel == g)),
      .in_ready (irdy[g]),
      .in_data  (in_data[CFG_W[g]-1:0]),
      .in_mode  (in_mode),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (dout),
      .out_ovf  (oo[g]),
      .out_zero (oz[g])
    );
    assign od[g] = 16'(dout);
  end

  // Signed integer arithmetic on the operand, then wrap to w bits.
  function automatic res_t model(input logic [15:0] x, input logic [1:0] m, input int w);
    longint sx;
    longint y;
    res_t   rr;
    sx = longint'(x) & ((longint'(1) << w) - 1);
    if (x[w-1]) sx = sx - (longint'(1) << w);
    case (m)
      2'b00:   y = sx;
      2'b01:   y = -sx;
      2'b10:   y = (sx < 0) ? -sx : sx;
      default: y = (sx > 0) ? -sx : sx;
    endcase
    rr.ovf  = (y >= (longint'(1) << (w - 1)));
    rr.data = 16'(y & ((longint'(1) << w) - 1));
    rr.zero = (rr.data == 16'd0);
    return rr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s (cfg %0d): got %h want %h", name, sel, got, want);
    end
  endtask

  task automatic reportFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s (cfg %0d): got no event want event", name, sel);
  endtask

  // Scoreboard: every cycle, compare the active instance against queued model results.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (ov[sel]) begin
        if (q.size() == 0) begin
          reportFail("expected result before out_valid");
        end else begin
          if (fresh) begin
            checkOutput("latency", cyc - q[0].acc, CFG_W[sel] / CFG_D[sel] + 1);
            fresh = 1'b0;
          end
          checkOutput("out_data", od[sel], q[0].r.data);
          checkOutput("out_ovf", oo[sel], q[0].r.ovf);
          checkOutput("out_zero", oz[sel], q[0].r.zero);
          if (out_ready) begin
            q.delete(0);
            fresh = 1'b1;
          end else begin
            checkOutput("in_ready while stalled", irdy[sel], 1'b0);
          end
        end
      end else if (q.size() == 0) begin
        checkOutput("in_ready when idle", irdy[sel], 1'b1);
      end else if (cyc - q[0].acc > CFG_W[sel] / CFG_D[sel] + 4) begin
        reportFail("out_valid timeout");
        q.delete(0);
        fresh = 1'b1;
      end
      if (in_valid && irdy[sel]) q.push_back('{model(in_data, in_mode, CFG_W[sel]), cyc});
    end
  end

  // Callers are always at posedge+1 when entering and leave at posedge+1.
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] m);
    logic hs;
    int   n;
    n        = 0;
    hs       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    do begin
      @(negedge clk);
      hs = irdy[sel];
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 50);
    if (!hs) reportFail("accept timeout");
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output res_t rr);
    int n;
    n  = 0;
    rr = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[sel] && n < 40);
    if (!ov[sel]) reportFail("result timeout");
    rr = '{ovf: oo[sel], zero: oz[sel], data: od[sel]};
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input string name, input logic [15:0] d, input logic [1:0] m,
                        input logic [15:0] edata, input logic eovf, input logic ezero);
    res_t rr;
    applyStimulus(d, m);
    waitResult(rr);
    checkOutput({name, " data"}, rr.data, edata);
    checkOutput({name, " ovf"}, rr.ovf, eovf);
    checkOutput({name, " zero"}, rr.zero, ezero);
  endtask

  task automatic drain();
    int n;
    n        = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) reportFail("drain timeout");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t rr;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = MODE_PASS;
    out_ready = 1'b1;

    // Hand-computed anchors for the model itself.
    checkOutput("model neg 05", model(16'h0005, MODE_NEG, 8), {2'b00, 16'h00FB});
    checkOutput("model neg 80", model(16'h0080, MODE_NEG, 8), {2'b10, 16'h0080});
    checkOutput("model abs F6", model(16'h00F6, MODE_ABS, 8), {2'b00, 16'h000A});
    checkOutput("model nabs 80", model(16'h0080, MODE_NABS, 8), {2'b00, 16'h0080});
    checkOutput("model pass 00", model(16'h0000, MODE_PASS, 8), {2'b01, 16'h0000});
    checkOutput("model neg 1234", model(16'h1234, MODE_NEG, 16), {2'b00, 16'hEDCC});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      checkOutput("reset out_valid", ov[g], 1'b0);
      checkOutput("reset out_data", od[g], 16'h0000);
      checkOutput("reset out_ovf", oo[g], 1'b0);
      checkOutput("reset out_zero", oz[g], 1'b0);
      checkOutput("reset in_ready", irdy[g], 1'b1);
    end
    @(posedge clk);
    #1;

    sel = 1;
    runOne("neg 05", 16'h05, MODE_NEG, 16'hFB, 1'b0, 1'b0);
    runOne("neg 80", 16'h80, MODE_NEG, 16'h80, 1'b1, 1'b0);
    runOne("abs F6", 16'hF6, MODE_ABS, 16'h0A, 1'b0, 1'b0);
    runOne("nabs 0A", 16'h0A, MODE_NABS, 16'hF6, 1'b0, 1'b0);
    runOne("nabs 80", 16'h80, MODE_NABS, 16'h80, 1'b0, 1'b0);
    runOne("pass 00", 16'h00, MODE_PASS, 16'h00, 1'b0, 1'b1);

    // Consumer stalls six cycles in DONE, then both handshakes land together.
    out_ready = 1'b0;
    applyStimulus(16'h33, MODE_NEG);
    waitResult(rr);
    checkOutput("stall first data", rr.data, 16'hCD);
    repeat (6) begin
      @(negedge clk);
      checkOutput("stall out_valid", ov[sel], 1'b1);
      checkOutput("stall out_data", od[sel], 16'hCD);
      checkOutput("stall in_ready", irdy[sel], 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    runOne("abs 7F after stall", 16'h7F, MODE_ABS, 16'h7F, 1'b0, 1'b0);
    drain();

    for (int g = 0; g < 4; g++) begin
      sel = g;
      for (int m = 0; m < 4; m++) begin
        for (int x = 0; x < 256; x++) applyStimulus(16'(x), 2'(m));
      end
      drain();
    end

    // Abort mid-operation in the second BUSY cycle.
    sel = 4;
    runOne("w16 neg 0001", 16'h0001, MODE_NEG, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h1234, MODE_NEG);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort out_valid", ov[sel], 1'b0);
    checkOutput("abort out_data", od[sel], 16'h0000);
    checkOutput("abort in_ready", irdy[sel], 1'b1);
    @(posedge clk);
    #1;
    runOne("w16 neg 1234", 16'h1234, MODE_NEG, 16'hEDCC, 1'b0, 1'b0);
    drain();

    sel = 5;
    runOne("w16d16 neg 8000", 16'h8000, MODE_NEG, 16'h8000, 1'b1, 1'b0);
    runOne("w16d16 neg 0001", 16'h0001, MODE_NEG, 16'hFFFF, 1'b0, 1'b0);
    runOne("w16d16 abs 8001", 16'h8001, MODE_ABS, 16'h7FFF, 1'b0, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
